// File: rtl/motor_array_emulator.sv
// Multi-channel stepper-motor emulator: synchronised step pulses integrate into saturating
// signed positions with active-low end switches, latched travel-fail flags and a hysteretic heat model.
module motor_array_emulator #(
  parameter int g_Channels        = 2,
  parameter int g_CounterBits     = 4,
  parameter int g_SwitchThreshold = 4,
  parameter int g_SyncStages      = 2,
  parameter int g_HeatMax         = 64,
  parameter int g_CoolDiv         = 256
) (
  input  logic                                      Clk_ik,
  input  logic                                      Rst_ir,
  input  logic [g_Channels-1:0]                     StepOutP_ib,
  input  logic [g_Channels-1:0]                     StepENAB_ib,
  input  logic [g_Channels-1:0]                     StepBOOST_ib,
  input  logic [g_Channels-1:0]                     StepDIR_ib,
  input  logic                                      PresetPos_i,
  input  logic                                      ClearFail_i,
  output logic [g_Channels-1:0]                     OH_ob,
  output logic [g_Channels-1:0]                     StepPFail_ob,
  output logic [g_Channels-1:0][1:0]                Switches_ob,
  output logic [g_Channels-1:0][g_CounterBits+1:0]  Position_omb
);

  localparam int PW = g_CounterBits + 2;
  localparam int HW = $clog2(2 * g_HeatMax + 1);
  localparam int DW = (g_CoolDiv > 1) ? $clog2(g_CoolDiv) : 1;

  localparam logic [PW-1:0] POS_R  = PW'(2 ** g_CounterBits);
  localparam logic [PW-1:0] POS_RN = PW'(-(2 ** g_CounterBits));
  localparam logic [PW-1:0] POS_T  = PW'(2 ** g_CounterBits - g_SwitchThreshold);
  localparam logic [PW-1:0] POS_TN = PW'(-(2 ** g_CounterBits - g_SwitchThreshold));

  localparam logic [HW:0] HEAT_SAT = (HW+1)'(2 * g_HeatMax);
  localparam logic [HW:0] HEAT_HI  = (HW+1)'(g_HeatMax);
  localparam logic [HW:0] HEAT_LO  = (HW+1)'(g_HeatMax / 2);

  localparam logic [DW-1:0] COOL_RELOAD = DW'(g_CoolDiv - 1);

  logic [g_SyncStages-1:0][g_Channels-1:0] sync_step, sync_dir, sync_enab, sync_boost;
  logic [g_Channels-1:0]                   prev_step;
  logic [g_Channels-1:0]                   step_ev, dir, enab, boost;

  logic [DW-1:0]                           cool_cnt;
  logic                                    tick;

  logic [g_Channels-1:0][PW-1:0]           pos_nxt;
  logic [g_Channels-1:0][1:0]              sw_nxt;
  logic [g_Channels-1:0]                   fail_nxt, oh_nxt;
  logic [g_Channels-1:0][HW-1:0]           heat_q, heat_nxt;
  logic [HW:0]                             heat_sum;

  // All control pins leave the synchroniser from the same stage so DIR/ENAB/BOOST line up with the step.
  assign step_ev = sync_step[g_SyncStages-1] & ~prev_step;
  assign dir     = sync_dir[g_SyncStages-1];
  assign enab    = sync_enab[g_SyncStages-1];
  assign boost   = sync_boost[g_SyncStages-1];

  assign tick = (cool_cnt == '0);

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      sync_step  <= '0;
      sync_dir   <= '0;
      sync_enab  <= '0;
      sync_boost <= '0;
      prev_step  <= '0;
      cool_cnt   <= '0;
    end else begin
      sync_step  <= {sync_step[g_SyncStages-2:0], StepOutP_ib};
      sync_dir   <= {sync_dir[g_SyncStages-2:0], StepDIR_ib};
      sync_enab  <= {sync_enab[g_SyncStages-2:0], StepENAB_ib};
      sync_boost <= {sync_boost[g_SyncStages-2:0], StepBOOST_ib};
      prev_step  <= sync_step[g_SyncStages-1];
      cool_cnt   <= tick ? COOL_RELOAD : cool_cnt - 1'b1;
    end
  end

  always_comb begin
    pos_nxt  = Position_omb;
    sw_nxt   = '1;
    fail_nxt = '0;
    oh_nxt   = OH_ob;
    heat_nxt = heat_q;
    heat_sum = '0;
    for (int i = 0; i < g_Channels; i++) begin
      if (PresetPos_i) begin
        pos_nxt[i] = '0;
      end else if (!enab[i] && step_ev[i]) begin
        if (dir[i]) begin
          if (Position_omb[i] != POS_R) pos_nxt[i] = Position_omb[i] + 1'b1;
        end else begin
          if (Position_omb[i] != POS_RN) pos_nxt[i] = Position_omb[i] - 1'b1;
        end
      end

      sw_nxt[i][0] = !($signed(pos_nxt[i]) >= $signed(POS_T));
      sw_nxt[i][1] = !($signed(pos_nxt[i]) <= $signed(POS_TN));

      // Hitting an end stop wins over a coincident clear.
      fail_nxt[i] = (pos_nxt[i] == POS_R) || (pos_nxt[i] == POS_RN) ||
                    (StepPFail_ob[i] && !ClearFail_i);

      heat_sum = {1'b0, heat_q[i]};
      if (!PresetPos_i && !enab[i] && step_ev[i])
        heat_sum = heat_sum + {{(HW-1){1'b0}}, boost[i], ~boost[i]};
      if (tick && heat_sum != '0)
        heat_sum = heat_sum - 1'b1;
      if (heat_sum > HEAT_SAT)
        heat_sum = HEAT_SAT;
      heat_nxt[i] = heat_sum[HW-1:0];

      if (heat_sum >= HEAT_HI)
        oh_nxt[i] = 1'b1;
      else if (heat_sum <= HEAT_LO)
        oh_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      Position_omb <= '0;
      Switches_ob  <= '1;
      StepPFail_ob <= '0;
      OH_ob        <= '0;
      heat_q       <= '0;
    end else begin
      Position_omb <= pos_nxt;
      Switches_ob  <= sw_nxt;
      StepPFail_ob <= fail_nxt;
      OH_ob        <= oh_nxt;
      heat_q       <= heat_nxt;
    end
  end

endmodule

// File: tb/tb_motor_array_emulator.sv
// Scoreboard bench for motor_array_emulator: a per-cycle reference model pushes expected outputs,
// an independent monitor pops and compares them one clock later.
module tb_motor_array_emulator;

  localparam int CH   = 2;
  localparam int CB   = 4;
  localparam int PW   = CB + 2;
  localparam int R    = 16;
  localparam int T    = 12;
  localparam int HMAX = 64;
  localparam int CD   = 256;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] step, enab, boost, dir;
  logic preset, clrf;
  logic [CH-1:0] oh, fail;
  logic [CH-1:0][1:0] sw;
  logic [CH-1:0][PW-1:0] pos;

  always #5 clk = ~clk;

  motor_array_emulator #(
    .g_Channels(CH), .g_CounterBits(CB), .g_SwitchThreshold(4),
    .g_SyncStages(2), .g_HeatMax(HMAX), .g_CoolDiv(CD)
  ) dut (
    .Clk_ik(clk), .Rst_ir(rst),
    .StepOutP_ib(step), .StepENAB_ib(enab), .StepBOOST_ib(boost), .StepDIR_ib(dir),
    .PresetPos_i(preset), .ClearFail_i(clrf),
    .OH_ob(oh), .StepPFail_ob(fail), .Switches_ob(sw), .Position_omb(pos)
  );

  typedef struct packed {
    logic [CH-1:0][PW-1:0] pos;
    logic [CH-1:0][1:0]    sw;
    logic [CH-1:0]         fail;
    logic [CH-1:0]         oh;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;

  // Reference model state
  int m_pos[CH];
  int m_heat[CH];
  bit m_fail[CH];
  bit m_oh[CH];
  int n_edge;
  logic [CH-1:0] h_step[4], h_dir[4], h_enab[4], h_boost[4];

  task automatic check_v(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 0; m_heat[i] = 0; m_fail[i] = 0; m_oh[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      h_step[k] = '0; h_dir[k] = '0; h_enab[k] = '0; h_boost[k] = '0;
    end
    n_edge = 0;
    q.delete();
  endtask

  // Inputs are applied at a negedge; model the upcoming posedge, push, then wait for the next negedge.
  // A pin level sampled at edge E acts at edge E+2; a step is a low-to-high change of the sampled pin.
  task automatic cycle();
    exp_t e;
    bit tick;
    for (int k = 3; k > 0; k--) begin
      h_step[k] = h_step[k-1]; h_dir[k] = h_dir[k-1];
      h_enab[k] = h_enab[k-1]; h_boost[k] = h_boost[k-1];
    end
    h_step[0] = step; h_dir[0] = dir; h_enab[0] = enab; h_boost[0] = boost;
    tick = (n_edge % CD) == 0;
    n_edge++;
    for (int i = 0; i < CH; i++) begin
      int np;
      int h;
      bit acc;
      acc = 0;
      np = m_pos[i];
      if (preset) np = 0;
      else if (!h_enab[2][i] && h_step[2][i] && !h_step[3][i]) begin
        acc = 1;
        np = h_dir[2][i] ? np + 1 : np - 1;
        if (np > R) np = R;
        if (np < -R) np = -R;
      end
      if (np == R || np == -R) m_fail[i] = 1;
      else if (clrf) m_fail[i] = 0;
      m_pos[i] = np;
      h = m_heat[i] + (acc ? (h_boost[2][i] ? 2 : 1) : 0) - (tick ? 1 : 0);
      if (h < 0) h = 0;
      if (h > 2 * HMAX) h = 2 * HMAX;
      m_heat[i] = h;
      if (h >= HMAX) m_oh[i] = 1;
      else if (h <= HMAX / 2) m_oh[i] = 0;
      e.pos[i]  = PW'(np);
      e.sw[i]   = {np > -T, np < T};
      e.fail[i] = m_fail[i];
      e.oh[i]   = m_oh[i];
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      pops++;
      check_v("sb_position", 32'(pos), 32'(e.pos));
      check_v("sb_switches", 32'(sw), 32'(e.sw));
      check_v("sb_fail", 32'(fail), 32'(e.fail));
      check_v("sb_oh", 32'(oh), 32'(e.oh));
    end
  end

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic pulses(int ch, int n, bit d, bit b);
    for (int p = 0; p < n; p++) begin
      step[ch] = 1'b1; dir[ch] = d; boost[ch] = b;
      repeat (2) cycle();
      step[ch] = 1'b0;
      repeat (2) cycle();
    end
  endtask

  task automatic preset_pulse();
    preset = 1'b1; cycle(); preset = 1'b0;
  endtask

  task automatic clear_pulse();
    clrf = 1'b1; cycle(); clrf = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check_v({tag, "_position"}, 32'(pos), 32'h0);
    check_v({tag, "_switches"}, 32'(sw), 32'hF);
    check_v({tag, "_fail"}, 32'(fail), 32'h0);
    check_v({tag, "_oh"}, 32'(oh), 32'h0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    step = '0; enab = '0; boost = '0; dir = '0; preset = 1'b0; clrf = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int left[CH];
    bit lvl[CH];
    rst = 1'b1;
    step = '0; enab = '0; boost = '0; dir = '0; preset = 1'b0; clrf = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 12 positive steps: switch 0 zone, channel 1 untouched
    pulses(0, 12, 1'b1, 1'b0);
    idle(4);
    check_v("t1_pos0", 32'(pos[0]), 32'd12);
    check_v("t1_sw0", 32'(sw[0]), 32'b10);
    check_v("t1_pos1", 32'(pos[1]), 32'd0);
    check_v("t1_sw1", 32'(sw[1]), 32'b11);

    // Negative travel to the end stop, fail latch and release
    preset_pulse();
    pulses(0, 20, 1'b0, 1'b0);
    idle(4);
    check_v("t2_pos_sat", 32'(pos[0]), 32'h30);
    check_v("t2_sw_neg", 32'(sw[0]), 32'b01);
    check_v("t2_fail_set", 32'(fail[0]), 32'd1);
    clear_pulse();
    idle(2);
    check_v("t2_fail_held", 32'(fail[0]), 32'd1);
    pulses(0, 1, 1'b1, 1'b0);
    idle(4);
    check_v("t2_pos_back", 32'(pos[0]), 32'h31);
    clear_pulse();
    idle(2);
    check_v("t2_fail_clear", 32'(fail[0]), 32'd0);

    // Disabled motor ignores steps; releasing ENAB mid-pulse adds nothing
    enab[0] = 1'b1;
    pulses(0, 10, 1'b1, 1'b0);
    step[0] = 1'b1; cycle(); cycle();
    enab[0] = 1'b0; cycle(); cycle();
    step[0] = 1'b0; idle(4);
    check_v("t3_pos_hold", 32'(pos[0]), 32'h31);

    // Preset landing on the same cycle as a step event
    step[0] = 1'b1; dir[0] = 1'b1;
    cycle(); cycle();
    step[0] = 1'b0; preset = 1'b1;
    cycle();
    preset = 1'b0;
    check_v("t4_pos_zero", 32'(pos[0]), 32'd0);
    check_v("t4_sw_idle", 32'(sw[0]), 32'b11);
    idle(4);
    check_v("t4_no_step", 32'(pos[0]), 32'd0);

    // Randomised traffic on both channels, direction bias alternating per segment
    for (int i = 0; i < CH; i++) begin left[i] = 0; lvl[i] = 0; end
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        preset = ($urandom_range(0, 149) == 0);
        clrf   = ($urandom_range(0, 39) == 0);
        for (int i = 0; i < CH; i++) begin
          if (left[i] == 0) begin
            lvl[i]  = ~lvl[i];
            left[i] = $urandom_range(2, 4);
            if (lvl[i]) begin
              dir[i]   = ($urandom_range(0, 3) != 0) ^ (seg % 2 == 1);
              enab[i]  = ($urandom_range(0, 9) == 0);
              boost[i] = $urandom_range(0, 1);
            end
          end
          step[i] = lvl[i];
          left[i]--;
        end
        cycle();
      end
    end
    step = '0; enab = '0; boost = '0; preset = 1'b0; clrf = 1'b0;
    idle(5);

    // Thermal model from a clean start: 32 boosted pulses, then cool down
    sync_reset();
    pulses(0, 32, 1'b1, 1'b1);
    idle(4);
    check_v("t5_oh_set", 32'(oh[0]), 32'd1);
    check_v("t5_oh_other", 32'(oh[1]), 32'd0);
    idle(8150 - n_edge);
    check_v("t5_oh_before", 32'(oh[0]), 32'd1);
    idle(8200 - n_edge);
    check_v("t5_oh_fallen", 32'(oh[0]), 32'd0);

    // Asynchronous reset in the middle of a pulse train
    boost[0] = 1'b0;
    preset_pulse();
    pulses(0, 7, 1'b1, 1'b0);
    idle(3);
    check_v("t6_pos7", 32'(pos[0]), 32'd7);
    step[0] = 1'b1;
    cycle();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    step = '0; dir = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    check_v("t6_pos_after", 32'(pos[0]), 32'd0);

    idle(3);
    check_v("sb_drained", 32'(q.size()), 32'd0);
    check_v("sb_active", 32'(pops > 5000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
